// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bundle: decode operands and control, EX/MEM and MEM/WB forward taps, ALU-facing outputs.
// Latency: none (wires only); the stage registers live in id_ex_stage.
// Backpressure: Stall/Flush travel with the bundle from hazard/branch logic; LoadUseHazard returns to decode.
// Ports: slave = the ID/EX stage (consumes decode + forward taps, drives ALU-side outputs); master = the driver side.
interface id_ex_stage_if #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
);
  // Pipeline control from hazard/branch logic
  logic                Stall;
  logic                Flush;
  // Decode side
  logic                InValid;
  logic [WIDTH-1:0]    ReadData1;
  logic [WIDTH-1:0]    ReadData2;
  logic [WIDTH-1:0]    SignImm;
  logic [REG_BITS-1:0] Rs;
  logic [REG_BITS-1:0] Rt;
  logic [REG_BITS-1:0] Rd;
  logic [3:0]          ALUControlIn;
  logic                ALUSrcIn;
  logic                RegDstIn;
  logic                RegWriteIn;
  logic                MemReadIn;
  logic                MemWriteIn;
  logic                MemToRegIn;
  // Forward taps from later stages
  logic                ExMemRegWrite;
  logic [REG_BITS-1:0] ExMemRd;
  logic [WIDTH-1:0]    ExMemResult;
  logic                MemWbRegWrite;
  logic [REG_BITS-1:0] MemWbRd;
  logic [WIDTH-1:0]    MemWbResult;
  // Execute side
  logic [3:0]          ALUControl;
  logic [WIDTH-1:0]    Data1;
  logic [WIDTH-1:0]    Data2;
  logic [WIDTH-1:0]    StoreData;
  logic [REG_BITS-1:0] WriteReg;
  logic                RegWrite;
  logic                MemRead;
  logic                MemWrite;
  logic                MemToReg;
  logic                Valid;
  logic                LoadUseHazard;

  modport slave (
    input  Stall, Flush, InValid, ReadData1, ReadData2, SignImm, Rs, Rt, Rd,
           ALUControlIn, ALUSrcIn, RegDstIn, RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn,
           ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbResult,
    output ALUControl, Data1, Data2, StoreData, WriteReg, RegWrite, MemRead, MemWrite,
           MemToReg, Valid, LoadUseHazard
  );

  modport master (
    output Stall, Flush, InValid, ReadData1, ReadData2, SignImm, Rs, Rt, Rd,
           ALUControlIn, ALUSrcIn, RegDstIn, RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn,
           ExMemRegWrite, ExMemRd, ExMemResult, MemWbRegWrite, MemWbRd, MemWbResult,
    input  ALUControl, Data1, Data2, StoreData, WriteReg, RegWrite, MemRead, MemWrite,
           MemToReg, Valid, LoadUseHazard
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM + MEM/WB operand forwarding, immediate select and load-use detect.
// Latency: 1 cycle decode -> ALU operands; forwarding muxes are combinational on the registered state.
// Backpressure: Stall holds every field, Flush (wins over Stall) inserts a bubble; LoadUseHazard asks decode to stall.
// Ports: clk, reset (sync, active-high), bus (id_ex_stage_if.slave) carrying decode inputs, forward taps and ALU outputs.
module id_ex_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic [3:0]          alu_ctrl;
    logic                alu_src;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic [REG_BITS-1:0] write_reg;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic [WIDTH-1:0]    imm;
  } stage_t;

  stage_t stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (bus.Flush) begin
      // Bubble: kill everything with a side effect; operand fields may stay stale.
      stage_d.valid      = 1'b0;
      stage_d.alu_ctrl   = 4'b0000;
      stage_d.reg_write  = 1'b0;
      stage_d.mem_read   = 1'b0;
      stage_d.mem_write  = 1'b0;
      stage_d.mem_to_reg = 1'b0;
    end else if (!bus.Stall) begin
      stage_d.valid      = bus.InValid;
      stage_d.alu_ctrl   = bus.ALUControlIn;
      stage_d.alu_src    = bus.ALUSrcIn;
      // Gate side-effect controls so an invalid slot is always a bubble.
      stage_d.reg_write  = bus.RegWriteIn & bus.InValid;
      stage_d.mem_read   = bus.MemReadIn  & bus.InValid;
      stage_d.mem_write  = bus.MemWriteIn & bus.InValid;
      stage_d.mem_to_reg = bus.MemToRegIn & bus.InValid;
      stage_d.write_reg  = bus.RegDstIn ? bus.Rd : bus.Rt;
      stage_d.rs         = bus.Rs;
      stage_d.rt         = bus.Rt;
      stage_d.rd1        = bus.ReadData1;
      stage_d.rd2        = bus.ReadData2;
      stage_d.imm        = bus.SignImm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Forward hit detection; register 0 is hardwired and never forwarded.
  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  assign ex_hit_a = bus.ExMemRegWrite && (bus.ExMemRd != '0) && (bus.ExMemRd == stage_q.rs);
  assign ex_hit_b = bus.ExMemRegWrite && (bus.ExMemRd != '0) && (bus.ExMemRd == stage_q.rt);
  assign wb_hit_a = bus.MemWbRegWrite && (bus.MemWbRd != '0) && (bus.MemWbRd == stage_q.rs);
  assign wb_hit_b = bus.MemWbRegWrite && (bus.MemWbRd != '0) && (bus.MemWbRd == stage_q.rt);

  logic [WIDTH-1:0] fwd_a, fwd_b;

  // EX/MEM is the younger result, so it wins when both stages match.
  always_comb begin
    fwd_a = stage_q.rd1;
    if (ex_hit_a) begin
      fwd_a = bus.ExMemResult;
    end else if (wb_hit_a) begin
      fwd_a = bus.MemWbResult;
    end
  end

  always_comb begin
    fwd_b = stage_q.rd2;
    if (ex_hit_b) begin
      fwd_b = bus.ExMemResult;
    end else if (wb_hit_b) begin
      fwd_b = bus.MemWbResult;
    end
  end

  assign bus.ALUControl = stage_q.alu_ctrl;
  assign bus.Data1      = fwd_a;
  assign bus.Data2      = stage_q.alu_src ? stage_q.imm : fwd_b;
  // Stores always need the register value, even when the ALU takes the immediate.
  assign bus.StoreData  = fwd_b;
  assign bus.WriteReg   = stage_q.write_reg;
  assign bus.RegWrite   = stage_q.reg_write;
  assign bus.MemRead    = stage_q.mem_read;
  assign bus.MemWrite   = stage_q.mem_write;
  assign bus.MemToReg   = stage_q.mem_to_reg;
  assign bus.Valid      = stage_q.valid;

  // A load here cannot forward its data in time to the instruction now in decode.
  assign bus.LoadUseHazard = stage_q.valid && stage_q.mem_read && (stage_q.write_reg != '0) &&
                             ((stage_q.write_reg == bus.Rs) || (stage_q.write_reg == bus.Rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding priority, r0, immediate, stall/flush, load-use.
// Latency: checks sampled 1ns after the capturing edge, combinational paths after a 1ns settle.
// Backpressure: Stall/Flush driven directly from the stimulus sequence.
module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  id_ex_stage_if #(.WIDTH(32), .REG_BITS(5)) bus ();

  id_ex_stage #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Stall = 0; bus.Flush = 0; bus.InValid = 0;
    bus.ReadData1 = '0; bus.ReadData2 = '0; bus.SignImm = '0;
    bus.Rs = '0; bus.Rt = '0; bus.Rd = '0;
    bus.ALUControlIn = 4'b0000; bus.ALUSrcIn = 0; bus.RegDstIn = 0;
    bus.RegWriteIn = 0; bus.MemReadIn = 0; bus.MemWriteIn = 0; bus.MemToRegIn = 0;
    bus.ExMemRegWrite = 0; bus.ExMemRd = '0; bus.ExMemResult = '0;
    bus.MemWbRegWrite = 0; bus.MemWbRd = '0; bus.MemWbResult = '0;
  endtask

  // Present one decoded instruction (forward taps untouched).
  task automatic present(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic alusrc, input logic regdst,
                         input logic regwr, input logic memrd, input logic memwr, input logic m2r);
    bus.InValid = 1; bus.ALUControlIn = op;
    bus.Rs = rs; bus.Rt = rt; bus.Rd = rd;
    bus.ReadData1 = d1; bus.ReadData2 = d2; bus.SignImm = imm;
    bus.ALUSrcIn = alusrc; bus.RegDstIn = regdst;
    bus.RegWriteIn = regwr; bus.MemReadIn = memrd; bus.MemWriteIn = memwr; bus.MemToRegIn = m2r;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clear_inputs();
    reset = 1;
    tick(); tick();

    // Power-on reset state
    check_eq("rst_valid",    32'(bus.Valid), 32'h0);
    check_eq("rst_regwrite", 32'(bus.RegWrite), 32'h0);
    check_eq("rst_aluctl",   32'(bus.ALUControl), 32'h0);
    check_eq("rst_writereg", 32'(bus.WriteReg), 32'h0);
    check_eq("rst_data1",    bus.Data1, 32'h0);
    check_eq("rst_data2",    bus.Data2, 32'h0);
    check_eq("rst_store",    bus.StoreData, 32'h0);
    reset = 0;

    // Plain add: Rs=3 (5), Rt=4 (7), RegDst -> Rd=9
    present(4'b0010, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("add_data1",    bus.Data1, 32'd5);
    check_eq("add_data2",    bus.Data2, 32'd7);
    check_eq("add_writereg", 32'(bus.WriteReg), 32'd9);
    check_eq("add_regwrite", 32'(bus.RegWrite), 32'h1);
    check_eq("add_valid",    32'(bus.Valid), 32'h1);
    check_eq("add_aluctl",   32'(bus.ALUControl), 32'h2);

    // Reset mid-stream, decode inputs still live
    reset = 1;
    tick();
    check_eq("mid_rst_valid",    32'(bus.Valid), 32'h0);
    check_eq("mid_rst_regwrite", 32'(bus.RegWrite), 32'h0);
    check_eq("mid_rst_aluctl",   32'(bus.ALUControl), 32'h0);
    check_eq("mid_rst_data1",    bus.Data1, 32'h0);
    check_eq("mid_rst_data2",    bus.Data2, 32'h0);
    reset = 0;

    // Double forward on Rs=8
    present(4'b0010, 5'd8, 5'd1, 5'd10, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus.ExMemRegWrite = 1; bus.ExMemRd = 5'd8; bus.ExMemResult = 32'h100;
    bus.MemWbRegWrite = 1; bus.MemWbRd = 5'd8; bus.MemWbResult = 32'h200;
    #1;
    check_eq("fwd_both_exmem", bus.Data1, 32'h100);
    check_eq("fwd_b_nohit",    bus.Data2, 32'h22);
    bus.ExMemRegWrite = 0;
    #1;
    check_eq("fwd_memwb", bus.Data1, 32'h200);
    bus.MemWbRegWrite = 0;
    #1;
    check_eq("fwd_none", bus.Data1, 32'h11);
    // MEM/WB alone on operand B
    bus.MemWbRegWrite = 1; bus.MemWbRd = 5'd1; bus.MemWbResult = 32'h333;
    #1;
    check_eq("fwd_b_memwb", bus.Data2, 32'h333);
    check_eq("fwd_b_store", bus.StoreData, 32'h333);
    clear_inputs();

    // Register 0 is never forwarded
    present(4'b0001, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus.ExMemRegWrite = 1; bus.ExMemRd = 5'd0; bus.ExMemResult = 32'hDEAD;
    bus.MemWbRegWrite = 1; bus.MemWbRd = 5'd0; bus.MemWbResult = 32'hBEEF;
    #1;
    check_eq("r0_data1", bus.Data1, 32'h0);
    check_eq("r0_data2", bus.Data2, 32'h0);
    clear_inputs();

    // Immediate select with a forwarded store value on Rt=5
    present(4'b0010, 5'd2, 5'd5, 5'd0, 32'h7, 32'h1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bus.ExMemRegWrite = 1; bus.ExMemRd = 5'd5; bus.ExMemResult = 32'h55;
    #1;
    check_eq("imm_data2", bus.Data2, 32'hFFFF_FFFC);
    check_eq("imm_store", bus.StoreData, 32'h55);
    check_eq("imm_data1", bus.Data1, 32'h7);
    clear_inputs();

    // Stall: hold for two cycles while decode changes
    present(4'b0010, 5'd1, 5'd2, 5'd7, 32'hA, 32'hB, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    bus.Stall = 1;
    present(4'b0110, 5'd7, 5'd8, 5'd9, 32'h99, 32'h98, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check_eq("stall_data1",    bus.Data1, 32'hA);
    check_eq("stall_data2",    bus.Data2, 32'hB);
    check_eq("stall_aluctl",   32'(bus.ALUControl), 32'h2);
    check_eq("stall_writereg", 32'(bus.WriteReg), 32'd2);
    check_eq("stall_regwrite", 32'(bus.RegWrite), 32'h1);
    check_eq("stall_memwrite", 32'(bus.MemWrite), 32'h1);
    check_eq("stall_valid",    32'(bus.Valid), 32'h1);
    // Forwarding still tracks while stalled
    bus.ExMemRegWrite = 1; bus.ExMemRd = 5'd1; bus.ExMemResult = 32'h777;
    #1;
    check_eq("stall_fwd", bus.Data1, 32'h777);
    bus.ExMemRegWrite = 0;

    // Flush beats Stall
    bus.Flush = 1;
    tick();
    check_eq("flush_valid",    32'(bus.Valid), 32'h0);
    check_eq("flush_regwrite", 32'(bus.RegWrite), 32'h0);
    check_eq("flush_memwrite", 32'(bus.MemWrite), 32'h0);
    check_eq("flush_aluctl",   32'(bus.ALUControl), 32'h0);
    clear_inputs();

    // Invalid input with controls set still loads as a bubble
    present(4'b0010, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    bus.InValid = 0;
    tick();
    check_eq("inv_valid",    32'(bus.Valid), 32'h0);
    check_eq("inv_regwrite", 32'(bus.RegWrite), 32'h0);
    check_eq("inv_memread",  32'(bus.MemRead), 32'h0);
    check_eq("inv_hazard",   32'(bus.LoadUseHazard), 32'h0);
    clear_inputs();

    // Load-use: lw writing r6
    present(4'b0010, 5'd1, 5'd6, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("lw_memtoreg", 32'(bus.MemToReg), 32'h1);
    check_eq("lw_writereg", 32'(bus.WriteReg), 32'd6);
    bus.Stall = 1;
    bus.Rs = 5'd1; bus.Rt = 5'd6;
    #1;
    check_eq("lu_rt_match", 32'(bus.LoadUseHazard), 32'h1);
    bus.Rs = 5'd6; bus.Rt = 5'd0;
    #1;
    check_eq("lu_rs_match", 32'(bus.LoadUseHazard), 32'h1);
    bus.Rs = 5'd1; bus.Rt = 5'd2;
    #1;
    check_eq("lu_no_match", 32'(bus.LoadUseHazard), 32'h0);
    bus.Stall = 0;

    // lw targeting r0 never raises a hazard
    present(4'b0010, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bus.Rs = 5'd0; bus.Rt = 5'd0;
    #1;
    check_eq("lu_r0", 32'(bus.LoadUseHazard), 32'h0);
    check_eq("lu_r0_memread", 32'(bus.MemRead), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute; directly feeds the ALU (ALUControl, Data1, Data2).
- Captures decoded operands and control, applies EX/MEM and MEM/WB result forwarding, selects the immediate for Data2, and flags load-use hazards back to decode.
- Supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

Parameters:
- WIDTH, 32, datapath width of operands and results.
- REG_BITS, 5, register specifier width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold all stage contents.
- Flush  in  1  replace captured instruction with a bubble.
- InValid  in  1  decode presents a real instruction.
- ReadData1, ReadData2  in  WIDTH  register file outputs for Rs, Rt.
- SignImm  in  WIDTH  sign-extended immediate.
- Rs, Rt, Rd  in  REG_BITS  decoded specifiers.
- ALUControlIn  in  4  ALU opcode (0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 NOR).
- ALUSrcIn, RegDstIn, RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn  in  1  decoded control.
- ExMemRegWrite  in  1  EX/MEM will write a register.
- ExMemRd  in  REG_BITS  EX/MEM destination.
- ExMemResult  in  WIDTH  EX/MEM ALU result.
- MemWbRegWrite  in  1  MEM/WB will write a register.
- MemWbRd  in  REG_BITS  MEM/WB destination.
- MemWbResult  in  WIDTH  MEM/WB writeback value.
- ALUControl  out  4  registered opcode to ALU.
- Data1, Data2  out  WIDTH  forwarded ALU operands (combinational from registered state and forward inputs).
- StoreData  out  WIDTH  forwarded Rt value for stores.
- WriteReg  out  REG_BITS  registered destination (Rd if RegDst else Rt).
- RegWrite, MemRead, MemWrite, MemToReg  out  1  registered control, zero when bubble.
- Valid  out  1  stage holds a real instruction.
- LoadUseHazard  out  1  combinational request to decode to stall.

Behaviour:
- reset (sync, priority over all): every stored field cleared to 0; Valid=0, all control=0, ALUControl=0000, WriteReg=0. Rs/Rt stored as 0, so Data1=Data2=StoreData=0 after reset.
- Priority per edge: reset > Flush > Stall > load.
- Flush: stored control (RegWrite, MemRead, MemWrite, MemToReg, Valid) cleared; ALUControl cleared to 0000. Flush overrides a simultaneous Stall.
- Stall (no Flush): all stored fields hold.
- Load (neither): all fields captured.
  - Valid <= InValid.
  - Control bits ANDed with InValid, so an invalid input is always a bubble.
  - WriteReg <= RegDstIn ? Rd : Rt.
  - ALUSrc, Rs, Rt, ReadData1/2 and SignImm stored.
- Latency: one cycle from decode inputs to ALU operands.
- Forwarding for operand A (stored Rs):
  - EX/MEM match: ExMemRegWrite & ExMemRd!=0 & ExMemRd==Rs -> ExMemResult.
  - Else MEM/WB match, same conditions -> MemWbResult.
  - Else stored ReadData1.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand B (stored Rt): same rule gives fwdB.
- Data2 = ALUSrc ? stored SignImm : fwdB. StoreData = fwdB always.
- Forwarding is continuous: while stalled, Data1/Data2 track changing forward inputs.
- LoadUseHazard = Valid & MemRead & WriteReg!=0 & (WriteReg==Rs input | WriteReg==Rt input).
  - Decode asserts Stall on the front end and Flush here. This block does not self-stall.
- Widths: no arithmetic performed. All selects are full WIDTH. No truncation or extension beyond the provided SignImm.

Test Plan:
- Reset mid-stream: load add (Rs=3, Rt=4, values 5, 7), then reset -> next cycle Valid=0, RegWrite=0, ALUControl=0000, Data1=Data2=0.
- Plain load: ALUControlIn=0010, ReadData1=5, ReadData2=7, ALUSrc=0, RegDst=1, Rd=9, no forward match -> next cycle Data1=5, Data2=7, WriteReg=9, RegWrite=1.
- Double forward: stored Rs=8; ExMemRd=8 with ExMemResult=0x100; MemWbRd=8 with MemWbResult=0x200; both RegWrite=1 -> Data1=0x100. Deassert ExMemRegWrite -> Data1=0x200.
- Register 0 and immediate:
  - Rs=0, ExMemRd=0, ExMemRegWrite=1, ExMemResult=0xDEAD, ReadData1=0 -> Data1=0.
  - ALUSrc=1, SignImm=0xFFFFFFFC, Rt forward match on 0x55 -> Data2=0xFFFFFFFC, StoreData=0x55.
- Stall/flush: Stall=1 for 2 cycles with new inputs -> outputs unchanged. Stall=1 and Flush=1 together -> bubble: Valid=0, RegWrite=MemWrite=0.
- Load-use: stored lw with MemRead=1, WriteReg=6; decode presents Rt=6 -> LoadUseHazard=1. Same with WriteReg=0 -> LoadUseHazard=0.
